// File: rtl/alu_core.sv
// 8-bit datapath ALU for the 2A03 core: AI/BI operand latches, five operations,
// registered result (add) with carry (acr) and overflow (avr) flags.
module alu_core (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] db,
  input  logic [7:0] sb,
  input  logic [7:0] adl,
  input  logic       sb_ai,
  input  logic       zero_ai,
  input  logic       db_bi,
  input  logic       ndb_bi,
  input  logic       adl_bi,
  input  logic       sums,
  input  logic       ands,
  input  logic       eors,
  input  logic       ors,
  input  logic       srs,
  input  logic       cin,
  output logic [7:0] add,
  output logic       acr,
  output logic       avr,
  output logic       add_valid
);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_SUM,
    OP_AND,
    OP_EOR,
    OP_OR,
    OP_SR
  } op_t;

  logic [7:0] ai_reg;
  logic [7:0] bi_reg;
  logic [7:0] ai_next;
  logic [7:0] bi_next;
  logic [7:0] and_bits;
  logic [7:0] eor_bits;
  logic [7:0] or_bits;
  logic [8:0] sum9;
  logic [7:0] add_next;
  logic       acr_next;
  logic       avr_next;
  op_t        op_sel;

  // Bitwise units operate per bit on the registered operands.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_logic
      assign and_bits[gi] = ai_reg[gi] & bi_reg[gi];
      assign eor_bits[gi] = ai_reg[gi] ^ bi_reg[gi];
      assign or_bits[gi]  = ai_reg[gi] | bi_reg[gi];
    end
  endgenerate

  assign sum9 = {1'b0, ai_reg} + {1'b0, bi_reg} + {8'd0, cin};

  always_comb begin
    ai_next = ai_reg;
    if (zero_ai)
      ai_next = 8'h00;
    else if (sb_ai)
      ai_next = sb;
  end

  always_comb begin
    bi_next = bi_reg;
    if (ndb_bi)
      bi_next = ~db;
    else if (db_bi)
      bi_next = db;
    else if (adl_bi)
      bi_next = adl;
  end

  always_comb begin
    op_sel = OP_NONE;
    if (sums)
      op_sel = OP_SUM;
    else if (ands)
      op_sel = OP_AND;
    else if (eors)
      op_sel = OP_EOR;
    else if (ors)
      op_sel = OP_OR;
    else if (srs)
      op_sel = OP_SR;
  end

  // No decimal correction: the D flag never reaches this block.
  always_comb begin
    add_next = add;
    acr_next = acr;
    avr_next = avr;
    case (op_sel)
      OP_SUM: begin
        add_next = sum9[7:0];
        acr_next = sum9[8];
        avr_next = (ai_reg[7] ~^ bi_reg[7]) & (ai_reg[7] ^ sum9[7]);
      end
      OP_AND: begin
        add_next = and_bits;
        acr_next = 1'b0;
        avr_next = 1'b0;
      end
      OP_EOR: begin
        add_next = eor_bits;
        acr_next = 1'b0;
        avr_next = 1'b0;
      end
      OP_OR: begin
        add_next = or_bits;
        acr_next = 1'b0;
        avr_next = 1'b0;
      end
      OP_SR: begin
        add_next = {cin, ai_reg[7:1]};
        acr_next = ai_reg[0];
        avr_next = 1'b0;
      end
      default: begin
        add_next = add;
        acr_next = acr;
        avr_next = avr;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ai_reg    <= 8'h00;
      bi_reg    <= 8'h00;
      add       <= 8'h00;
      acr       <= 1'b0;
      avr       <= 1'b0;
      add_valid <= 1'b0;
    end else begin
      ai_reg    <= ai_next;
      bi_reg    <= bi_next;
      add       <= add_next;
      acr       <= acr_next;
      avr       <= avr_next;
      add_valid <= (op_sel != OP_NONE);
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: expected results are queued when an operation
// is driven and popped when add_valid is observed after the edge.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] db = 8'h00, sb = 8'h00, adl = 8'h00;
  logic       sb_ai = 0, zero_ai = 0, db_bi = 0, ndb_bi = 0, adl_bi = 0;
  logic       sums = 0, ands = 0, eors = 0, ors = 0, srs = 0, cin = 0;
  logic [7:0] add;
  logic       acr, avr, add_valid;

  int checks = 0;
  int errors = 0;

  logic [9:0] sb_q[$];
  logic [7:0] m_ai = 8'h00, m_bi = 8'h00;
  logic [9:0] m_hold = 10'd0;

  alu_core dut (
    .clk(clk), .rst(rst), .db(db), .sb(sb), .adl(adl),
    .sb_ai(sb_ai), .zero_ai(zero_ai), .db_bi(db_bi), .ndb_bi(ndb_bi), .adl_bi(adl_bi),
    .sums(sums), .ands(ands), .eors(eors), .ors(ors), .srs(srs), .cin(cin),
    .add(add), .acr(acr), .avr(avr), .add_valid(add_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result {add, acr, avr} from the operation definitions.
  function automatic logic [9:0] model(input logic [4:0] op, input logic c,
                                       input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic       v;
    s = 9'(a) + 9'(b) + 9'(c);
    v = (a[7] == b[7]) && (s[7] != a[7]);
    if (op[4])      return {s[7:0], s[8], v};
    else if (op[3]) return {a & b, 2'b00};
    else if (op[2]) return {a ^ b, 2'b00};
    else if (op[1]) return {a | b, 2'b00};
    else            return {c, a[7:1], a[0], 1'b0};
  endfunction

  // ld = {zero_ai, sb_ai, ndb_bi, db_bi, adl_bi}; op = {sums, ands, eors, ors, srs}
  task automatic apply(input string tag, input logic [7:0] d, input logic [7:0] s,
                       input logic [7:0] a, input logic [4:0] ld,
                       input logic [4:0] op, input logic c);
    logic [9:0] got;
    @(negedge clk);
    db = d; sb = s; adl = a; cin = c;
    {zero_ai, sb_ai, ndb_bi, db_bi, adl_bi} = ld;
    {sums, ands, eors, ors, srs} = op;
    if (op != 5'd0) begin
      m_hold = model(op, c, m_ai, m_bi);
      sb_q.push_back(m_hold);
    end
    if (ld[4])      m_ai = 8'h00;
    else if (ld[3]) m_ai = s;
    if (ld[2])      m_bi = ~d;
    else if (ld[1]) m_bi = d;
    else if (ld[0]) m_bi = a;
    @(posedge clk);
    #1;
    got = {add, acr, avr};
    if (op != 5'd0) begin
      check({tag, "_valid"}, 32'(add_valid), 32'd1);
      if (sb_q.size() == 0) check({tag, "_queue"}, 32'd0, 32'd1);
      else check({tag, "_res"}, 32'(got), 32'(sb_q.pop_front()));
    end else begin
      check({tag, "_novalid"}, 32'(add_valid), 32'd0);
      check({tag, "_hold"}, 32'(got), 32'(m_hold));
    end
  endtask

  task automatic idle();
    @(negedge clk);
    {zero_ai, sb_ai, ndb_bi, db_bi, adl_bi} = 5'd0;
    {sums, ands, eors, ors, srs} = 5'd0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'({add, acr, avr, add_valid}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Overflow on add
    apply("ovf_ld", 8'h50, 8'h50, 8'h00, 5'b01010, 5'b00000, 1'b0);
    apply("ovf_sum", 8'h00, 8'h00, 8'h00, 5'b00000, 5'b10000, 1'b0);
    check("ovf_const", 32'({add, acr, avr}), 32'({8'hA0, 1'b0, 1'b1}));
    apply("ovf_after", 8'h00, 8'h00, 8'h00, 5'b00000, 5'b00000, 1'b0);

    // Subtract with borrow
    apply("sub_ld", 8'hF0, 8'h50, 8'h00, 5'b01100, 5'b00000, 1'b0);
    apply("sub_sum", 8'h00, 8'h00, 8'h00, 5'b00000, 5'b10000, 1'b1);
    check("sub_const", 32'({add, acr, avr}), 32'({8'h60, 1'b0, 1'b0}));

    // Carry wrap
    apply("wrap_ld", 8'h00, 8'hFF, 8'h01, 5'b01001, 5'b00000, 1'b0);
    apply("wrap_sum", 8'h00, 8'h00, 8'h00, 5'b00000, 5'b10000, 1'b0);
    check("wrap_const", 32'({add, acr, avr}), 32'({8'h00, 1'b1, 1'b0}));

    // Shift right then AND
    apply("sr_ld", 8'h0F, 8'h81, 8'h00, 5'b01010, 5'b00000, 1'b0);
    apply("sr_op", 8'h00, 8'h00, 8'h00, 5'b00000, 5'b00001, 1'b1);
    check("sr_const", 32'({add, acr}), 32'({8'hC0, 1'b1}));
    apply("and_op", 8'h00, 8'h00, 8'h00, 5'b00000, 5'b01000, 1'b0);
    check("and_const", 32'({add, acr}), 32'({8'h01, 1'b0}));

    // Priority and same-cycle load
    apply("pri_ld", 8'h5A, 8'h33, 8'h00, 5'b11010, 5'b00000, 1'b0);
    apply("pri_or", 8'h00, 8'h00, 8'h00, 5'b00000, 5'b00010, 1'b0);
    check("pri_const", 32'(add), 32'h5A);
    apply("same_sum", 8'hC3, 8'h00, 8'h00, 5'b00010, 5'b10100, 1'b0);
    check("same_old_bi", 32'(add), 32'h5A);
    apply("same_eor", 8'h00, 8'h00, 8'h00, 5'b00000, 5'b00100, 1'b0);
    check("same_new_bi", 32'(add), 32'hC3);

    // Reset mid-operation: load plus an op so outputs are nonzero before reset
    apply("mid_ld", 8'h11, 8'h22, 8'h00, 5'b01010, 5'b00010, 1'b0);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst", 32'({add, acr, avr, add_valid}), 32'd0);
    m_ai = 8'h00; m_bi = 8'h00; m_hold = 10'd0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    apply("post_rst", 8'h00, 8'h00, 8'h00, 5'b00000, 5'b10000, 1'b1);
    check("post_rst_const", 32'({add, acr, avr}), 32'({8'h01, 1'b0, 1'b0}));

    // Back-to-back random traffic
    for (int i = 0; i < 60; i++) begin
      apply("rnd", 8'($urandom), 8'($urandom), 8'($urandom),
            5'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            1'($urandom));
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_core.md
# alu_core

Eight-bit datapath ALU for the 2A03 CPU core. It latches operands from the internal buses into the A and B input registers and evaluates one of five operations. The result is held in the adder hold register. It also produces the carry (acr) and overflow (avr) flags that the processor status register samples through its ACR_C and AVR_V enables. Decimal mode is not implemented, matching the 2A03, so the D flag has no effect on this block.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  reset: asynchronous, active-high
- db  in  8  data bus
- sb  in  8  special bus
- adl  in  8  address-low bus
- sb_ai  in  1  load AI from sb
- zero_ai  in  1  load AI with 0x00
- db_bi  in  1  load BI from db
- ndb_bi  in  1  load BI with ~db
- adl_bi  in  1  load BI from adl
- sums  in  1  operation: AI + BI + cin
- ands  in  1  operation: AI & BI
- eors  in  1  operation: AI ^ BI
- ors  in  1  operation: AI | BI
- srs  in  1  operation: shift right, {cin, AI[7:1]}
- cin  in  1  carry in, used by sums and srs
- add  out  8  adder hold register
- acr  out  1  registered carry out
- avr  out  1  registered overflow
- add_valid  out  1  one-cycle pulse when add, acr and avr were updated on the preceding edge

## Operation
- Internal state: ai[7:0], bi[7:0], add, acr, avr, add_valid.
- **AI load priority** (one source per edge):
  - zero_ai wins over sb_ai.
  - With neither asserted, ai holds.
- **BI load priority:** ndb_bi > db_bi > adl_bi. With none asserted, bi holds.
- **Operation select priority:** sums > ands > eors > ors > srs.
  - With none asserted: add, acr and avr hold, and add_valid is 0 on the next edge.
- **sums:**
  - The 9-bit result is ai + bi + cin; add takes bits [7:0] and acr takes bit 8.
  - avr = (ai[7] ~^ bi[7]) & (ai[7] ^ add_next[7]).
- **ands / eors / ors:** add gets the bitwise result; acr = 0; avr = 0.
- **srs:** add = {cin, ai[7:1]}; acr = ai[0]; avr = 0.
- Subtraction is performed by the controller: ndb_bi together with sums and cin = 1 (borrow is the inverse of acr).
- Operations always read the registered ai/bi values present before the current edge.
- No decimal correction under any input.

## Timing
- **Reset values** while rst is asserted (asynchronous, immediate): ai = 0x00, bi = 0x00, add = 0x00, acr = 0, avr = 0, add_valid = 0.
- **Operand latency:** a load strobe at edge N makes the new ai/bi available to an operation strobe sampled at edge N+1.
- **Result latency:** an operation strobe sampled at edge N updates add/acr/avr at edge N.
  - add_valid is 1 during cycle N to N+1, i.e. one cycle.
  - Total load-to-result latency is 2 edges.
- **Same-cycle load and operation:** at edge N both take effect. The operation uses the pre-edge ai/bi, and the newly loaded values are used by the next operation.
- **Back-to-back operations** each produce a result every cycle; add_valid stays high while strobes continue.
- **Reset mid-operation:** all state clears immediately. Strobes sampled on the first edge after rst deasserts act normally.
- **Wrap-around:** the 8-bit sum wraps modulo 256, and acr captures the carry. Operands are unsigned with no saturation.
- Outputs are purely registered; no combinational path from inputs to add, acr or avr.

## Test plan
- **Overflow on add:** load sb = 0x50 (sb_ai) and db = 0x50 (db_bi), then sums with cin = 0 -> add = 0xA0, acr = 0, avr = 1, add_valid pulses once.
- **Subtract with borrow:** ai = 0x50, ndb_bi with db = 0xF0, sums with cin = 1 -> add = 0x60, acr = 0 (borrow), avr = 0.
- **Carry wrap:** ai = 0xFF, bi = 0x01, sums with cin = 0 -> add = 0x00, acr = 1, avr = 0.
- **Shift right and a logic op:**
  - ai = 0x81, srs with cin = 1 -> add = 0xC0, acr = 1.
  - Then ands with bi = 0x0F -> add = 0x01, acr = 0.
- **Priority and same-cycle load:**
  - zero_ai and sb_ai together with sb = 0x33 -> ai = 0x00.
  - sums, eors and a new db_bi load in the same cycle -> the sum uses the old bi, and the next eors uses the new bi.
- **Reset mid-operation:** assert rst between the operand load and the sums strobe -> add = 0x00, acr = 0, avr = 0, add_valid = 0 immediately; a later sums gives 0x00 + 0x00 + cin.
